// File: rtl/control_fsm_pkg.sv
// Shared types for the multicycle RV32I control FSM: state codes, opcodes,
// datapath mux/ALU encodings and the packed control bundle.
package control_fsm_pkg;

  localparam int OPCODE_W = 7;
  localparam int STATE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_JALR     = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_ITYPE = 3'b011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic       ir_write;
    logic       reg_write;
    logic       pc_update;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

endpackage

// File: rtl/control_fsm_if.sv
// Opcode in / control bundle out between the control FSM (master) and datapath (slave).
interface control_fsm_if;
  import control_fsm_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                AdrSrc;
  logic                IRWrite;
  logic                RegWrite;
  logic                PCUpdate;
  logic                MemWrite;
  logic                Branch;
  logic [1:0]          ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [2:0]          ALUOp;
  logic [1:0]          ResultSrc;
  logic [STATE_W-1:0]  FSMState;

  modport master (
    input  opcode,
    output AdrSrc, IRWrite, RegWrite, PCUpdate, MemWrite, Branch,
    output ALUSrcA, ALUSrcB, ALUOp, ResultSrc, FSMState
  );

  modport slave (
    output opcode,
    input  AdrSrc, IRWrite, RegWrite, PCUpdate, MemWrite, Branch,
    input  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, FSMState
  );
endinterface

// File: rtl/control_fsm_out_dec.sv
// Combinational state -> control bundle decoder; zero latency, no backpressure.
// JALR state decode present only with CONTROL_FSM_JALR_EN.
module control_fsm_out_dec
  import control_fsm_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_update  = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
      end
      // Branch/jump target is precomputed into ALUOut while the opcode decodes.
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEMDATA;
      end
      S_MEMWRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ITYPE;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_JAL: begin
        ctrl.pc_update  = 1'b1;
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
      end
      S_BEQ: begin
        ctrl.branch     = 1'b1;
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
      end
`ifdef CONTROL_FSM_JALR_EN
      S_JALR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Moore main control FSM of the multicycle RV32I core; one state per clock, outputs from state only.
// No stalls or backpressure; CONTROL_FSM_JALR_EN adds the JALR state (code 11).
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  control_fsm_if.master bus
);

  state_t state_q, state_d;
  logic   store_q, store_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

  // Opcode is only valid in DECODE, so load vs store is remembered for MEMADR.
  always_comb begin
    state_d = S_FETCH;
    store_d = store_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        store_d = (bus.opcode == OP_STORE);
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BEQ;
`ifdef CONTROL_FSM_JALR_EN
          OP_JALR:           state_d = S_JALR;
`endif
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = store_q ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef CONTROL_FSM_JALR_EN
      S_JALR:     state_d = S_JAL;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  control_fsm_out_dec u_out_dec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign bus.AdrSrc    = ctrl.adr_src;
  assign bus.IRWrite   = ctrl.ir_write;
  assign bus.RegWrite  = ctrl.reg_write;
  assign bus.PCUpdate  = ctrl.pc_update;
  assign bus.MemWrite  = ctrl.mem_write;
  assign bus.Branch    = ctrl.branch;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.ResultSrc = ctrl.result_src;
  assign bus.FSMState  = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each opcode class through its state
// sequence and checks state code plus full control bundle every cycle.
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] exp_seq [8];

  control_fsm_if bus ();

  control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // {AdrSrc,IRWrite,RegWrite,PCUpdate,MemWrite,Branch,ALUSrcA,ALUSrcB,ALUOp,ResultSrc}
  function automatic logic [14:0] exp_bundle(input logic [3:0] s);
    case (s)
      4'd0:    return 15'b0_1_0_1_0_0_00_10_000_10;
      4'd1:    return 15'b0_0_0_0_0_0_01_01_000_00;
      4'd2:    return 15'b0_0_0_0_0_0_10_01_000_00;
      4'd3:    return 15'b1_0_0_0_0_0_00_00_000_00;
      4'd4:    return 15'b0_0_1_0_0_0_00_00_000_01;
      4'd5:    return 15'b1_0_0_0_1_0_00_00_000_00;
      4'd6:    return 15'b0_0_0_0_0_0_10_00_010_00;
      4'd7:    return 15'b0_0_1_0_0_0_00_00_000_00;
      4'd8:    return 15'b0_0_0_0_0_0_10_01_011_00;
      4'd9:    return 15'b0_0_0_1_0_0_01_10_000_00;
      4'd10:   return 15'b0_0_0_0_0_1_10_00_001_00;
`ifdef CONTROL_FSM_JALR_EN
      4'd11:   return 15'b0_0_0_0_0_0_10_01_000_00;
`endif
      default: return 15'b0;
    endcase
  endfunction

  function automatic logic [14:0] obs_bundle();
    return {bus.AdrSrc, bus.IRWrite, bus.RegWrite, bus.PCUpdate, bus.MemWrite, bus.Branch,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ResultSrc};
  endfunction

  task automatic check_state(input string tag, input logic [3:0] s);
    chk({tag, "/state"}, {28'd0, bus.FSMState}, {28'd0, s});
    chk({tag, "/ctrl"}, {17'd0, obs_bundle()}, {17'd0, exp_bundle(s)});
  endtask

  // Entered at a falling edge in FETCH; opcode is corrupted once DECODE is past.
  task automatic run(input string tag, input logic [6:0] op, input int n);
    bus.opcode = op;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      check_state($sformatf("%s[%0d]", tag, i), exp_seq[i]);
      if (i == 2) bus.opcode = op ^ 7'h20;
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.opcode = OP_RTYPE;
    #5;
    check_state("rst_hold", 4'd0);
    @(negedge clk);
    check_state("rst_edge", 4'd0);
    reset = 1'b0;
    #1;
    check_state("rst_rel", 4'd0);

    exp_seq = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    run("rtype", OP_RTYPE, 5);
    exp_seq = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    run("itype", OP_ITYPE, 5);
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0};
    run("load", OP_LOAD, 6);
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    run("store", OP_STORE, 5);
    exp_seq = '{4'd0, 4'd1, 4'd9, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    run("jal", OP_JAL, 5);
    exp_seq = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run("branch", OP_BRANCH, 4);
    exp_seq = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run("nop0", 7'b0000000, 3);
    run("ecall", 7'b1110011, 3);
`ifdef CONTROL_FSM_JALR_EN
    exp_seq = '{4'd0, 4'd1, 4'd11, 4'd9, 4'd7, 4'd0, 4'd0, 4'd0};
    run("jalr", OP_JALR, 6);
`else
    exp_seq = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run("jalr_off", OP_JALR, 3);
`endif
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0};
    run("ld_abort", OP_LOAD, 4);
    #3;
    reset = 1'b1;
    #1;
    check_state("abort_async", 4'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("abort_rel", 4'd0);
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    run("store2", OP_STORE, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
